// File: rtl/cache_tg_pkg.sv
// Shared encodings for the cache traffic generator: run modes and FSM states.
package cache_tg_pkg;

  localparam logic [1:0] MODE_WR_ONLY = 2'd0;
  localparam logic [1:0] MODE_RD_ONLY = 2'd1;
  localparam logic [1:0] MODE_SEQ     = 2'd2;
  localparam logic [1:0] MODE_ALT     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_WR = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } tg_state_e;

endpackage

// File: rtl/cache_tg_checker.sv
// Read-data checker: counts mismatches (saturating) and captures the address
// of the first mismatch since the last clear.
module cache_tg_checker #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              chk_vld,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W-1:0] addr,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic seen;
  logic mis;

  assign mis = chk_vld && (rd_data != exp_data);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count      <= '0;
      first_err_addr <= '0;
      seen           <= 1'b0;
    end else if (clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
      seen           <= 1'b0;
    end else if (mis) begin
      if (err_count != '1) err_count <= err_count + ERR_W'(1);
      if (!seen) begin
        seen           <= 1'b1;
        first_err_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/cache_traffic_gen.sv
// Core-side cache traffic generator: issues strided write/read sequences,
// waits on the cache fin handshakes and checks read data against seed+i.
module cache_traffic_gen
  import cache_tg_pkg::*;
#(
  parameter int                ADDR_W  = 27,
  parameter int                DATA_W  = 32,
  parameter int                CNT_W   = 10,
  parameter logic [ADDR_W-1:0] STRIDE  = 27'h080_140C,
  parameter int                TIMEOUT = 1024,
  parameter int                ERR_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_ops,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] seed,
  input  logic              check_en,
  input  logic              cache2core_wr_fin,
  input  logic              cache2core_rd_fin,
  input  logic [DATA_W-1:0] cache2core_rd_data,
  output logic [ADDR_W-1:0] core2cache_rd_addr,
  output logic [ADDR_W-1:0] core2cache_wr_addr,
  output logic [DATA_W-1:0] core2cache_wr_data,
  output logic              core2cache_rd_en,
  output logic              core2cache_wr_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       cycle_count
);

  localparam int               TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  tg_state_e         state, state_n;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  nops_q, idx, idx_n;
  logic [ADDR_W-1:0] base_q, cur_addr, addr_n;
  logic [DATA_W-1:0] seed_q, cur_data, data_n;
  logic              chk_q;
  logic [TO_W-1:0]   wait_cnt;
  logic              go, issue_wr, issue_rd, finish, to_hit;
  logic              wr_acc, rd_acc, last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next op selection; cur_addr/cur_data always describe the op in flight.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    addr_n   = cur_addr;
    data_n   = cur_data;
    go       = 1'b0;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    finish   = 1'b0;
    to_hit   = 1'b0;
    wr_acc   = (state == ST_WAIT_WR) && cache2core_wr_fin;
    rd_acc   = (state == ST_WAIT_RD) && cache2core_rd_fin;
    last     = (idx == nops_q - CNT_W'(1));
    case (state)
      ST_IDLE: if (start) begin
        go     = 1'b1;
        idx_n  = '0;
        addr_n = base_addr;
        data_n = seed;
        if (num_ops == '0)              finish   = 1'b1;
        else if (mode == MODE_RD_ONLY)  issue_rd = 1'b1;
        else                            issue_wr = 1'b1;
      end
      ST_WAIT_WR: if (wr_acc) begin
        if (mode_q == MODE_ALT) begin
          issue_rd = 1'b1;
        end else if (!last) begin
          idx_n    = idx + CNT_W'(1);
          addr_n   = cur_addr + STRIDE;
          data_n   = cur_data + DATA_W'(1);
          issue_wr = 1'b1;
        end else if (mode_q == MODE_SEQ) begin
          idx_n    = '0;
          addr_n   = base_q;
          data_n   = seed_q;
          issue_rd = 1'b1;
        end else begin
          finish = 1'b1;
        end
      end else if (wait_cnt == TO_LAST) begin
        to_hit = 1'b1;
      end
      ST_WAIT_RD: if (rd_acc) begin
        if (last) begin
          finish = 1'b1;
        end else begin
          idx_n  = idx + CNT_W'(1);
          addr_n = cur_addr + STRIDE;
          data_n = cur_data + DATA_W'(1);
          if (mode_q == MODE_ALT) issue_wr = 1'b1;
          else                    issue_rd = 1'b1;
        end
      end else if (wait_cnt == TO_LAST) begin
        to_hit = 1'b1;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (issue_wr)              state_n = ST_WAIT_WR;
    else if (issue_rd)         state_n = ST_WAIT_RD;
    else if (finish || to_hit) state_n = ST_DONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q             <= '0;
      nops_q             <= '0;
      base_q             <= '0;
      seed_q             <= '0;
      chk_q              <= 1'b0;
      idx                <= '0;
      cur_addr           <= '0;
      cur_data           <= '0;
      wait_cnt           <= '0;
      core2cache_rd_addr <= '0;
      core2cache_wr_addr <= '0;
      core2cache_wr_data <= '0;
      core2cache_rd_en   <= 1'b0;
      core2cache_wr_en   <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      timeout            <= 1'b0;
      cycle_count        <= '0;
    end else begin
      core2cache_wr_en <= issue_wr;
      core2cache_rd_en <= issue_rd;
      done             <= finish || to_hit;
      idx              <= idx_n;
      cur_addr         <= addr_n;
      cur_data         <= data_n;
      if (issue_wr) begin
        core2cache_wr_addr <= addr_n;
        core2cache_wr_data <= data_n;
      end
      if (issue_rd) core2cache_rd_addr <= addr_n;
      if (issue_wr || issue_rd) wait_cnt <= '0;
      else if (state == ST_WAIT_WR || state == ST_WAIT_RD) wait_cnt <= wait_cnt + TO_W'(1);
      if (go) begin
        mode_q      <= mode;
        nops_q      <= num_ops;
        base_q      <= base_addr;
        seed_q      <= seed;
        chk_q       <= check_en;
        timeout     <= 1'b0;
        cycle_count <= '0;
        busy        <= (num_ops != '0);
      end else begin
        if (busy) cycle_count <= cycle_count + 32'd1;
        if (finish || to_hit) busy <= 1'b0;
        if (to_hit) timeout <= 1'b1;
      end
    end
  end

  cache_tg_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W)
  ) u_checker (
    .clk            (clk),
    .rstn           (rstn),
    .clear          (go),
    .chk_vld        (rd_acc && chk_q),
    .rd_data        (cache2core_rd_data),
    .exp_data       (cur_data),
    .addr           (cur_addr),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Randomized bench for cache_traffic_gen: a cache responder with memory and a
// list-based op model predict op streams, error counts and cycle counts.
module tb_cache_traffic_gen;

  localparam int AW = 27, DW = 32, CW = 10, EW = 16, TO = 16;
  localparam logic [AW-1:0] STR = 27'h080_140C;

  logic          clk = 1'b0, rstn = 1'b1, start = 1'b0, check_en = 1'b0;
  logic          cache2core_wr_fin = 1'b0, cache2core_rd_fin = 1'b0;
  logic [1:0]    mode = '0;
  logic [CW-1:0] num_ops = '0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] seed = '0, cache2core_rd_data = '0;
  logic [AW-1:0] core2cache_rd_addr, core2cache_wr_addr, first_err_addr;
  logic [DW-1:0] core2cache_wr_data;
  logic          core2cache_rd_en, core2cache_wr_en, busy, done, timeout;
  logic [EW-1:0] err_count;
  logic [31:0]   cycle_count;

  always #5 clk = ~clk;

  cache_traffic_gen #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .STRIDE(STR), .TIMEOUT(TO), .ERR_W(EW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .num_ops(num_ops),
    .base_addr(base_addr), .seed(seed), .check_en(check_en),
    .cache2core_wr_fin(cache2core_wr_fin), .cache2core_rd_fin(cache2core_rd_fin),
    .cache2core_rd_data(cache2core_rd_data),
    .core2cache_rd_addr(core2cache_rd_addr), .core2cache_wr_addr(core2cache_wr_addr),
    .core2cache_wr_data(core2cache_wr_data), .core2cache_rd_en(core2cache_rd_en),
    .core2cache_wr_en(core2cache_wr_en), .busy(busy), .done(done), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr), .cycle_count(cycle_count)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] junk(input logic [AW-1:0] a);
    return {5'h15, a};
  endfunction

  // Cache responder: logs every request, stores writes, answers after a random latency
  // and sprinkles in fins of the wrong kind that must be ignored.
  bit            obs_w[$];
  logic [AW-1:0] obs_a[$];
  logic [DW-1:0] obs_d[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            cd = 0, lat = 0, lat_sum = 0, rd_seen = 0;
  bit            cd_rd = 1'b0;
  logic [DW-1:0] cd_data = '0;
  int            lat_lo = 1, lat_hi = 4, corrupt = -1;
  bit            no_fin = 1'b0;

  always @(negedge clk) begin
    cache2core_wr_fin = 1'b0;
    cache2core_rd_fin = 1'b0;
    if (!rstn) cd = 0;
    else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (cd_rd) begin cache2core_rd_fin = 1'b1; cache2core_rd_data = cd_data; end
          else cache2core_wr_fin = 1'b1;
        end else if (!no_fin && $urandom_range(3, 0) == 0) begin
          if (cd_rd) cache2core_wr_fin = 1'b1;
          else begin cache2core_rd_fin = 1'b1; cache2core_rd_data = $urandom; end
        end
      end
      if (core2cache_wr_en) begin
        obs_w.push_back(1'b1); obs_a.push_back(core2cache_wr_addr); obs_d.push_back(core2cache_wr_data);
        mem[core2cache_wr_addr] = core2cache_wr_data;
        cd_rd = 1'b0;
        lat = $urandom_range(lat_hi, lat_lo);
        cd = no_fin ? 0 : lat;
        if (!no_fin) lat_sum += lat + 1;
      end
      if (core2cache_rd_en) begin
        obs_w.push_back(1'b0); obs_a.push_back(core2cache_rd_addr); obs_d.push_back('0);
        cd_data = mem.exists(core2cache_rd_addr) ? mem[core2cache_rd_addr] : junk(core2cache_rd_addr);
        if (rd_seen == corrupt) cd_data = cd_data ^ 32'd1;
        rd_seen++;
        cd_rd = 1'b1;
        lat = $urandom_range(lat_hi, lat_lo);
        cd = no_fin ? 0 : lat;
        if (!no_fin) lat_sum += lat + 1;
      end
    end
  end

  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  task automatic run(input string tag, input int md, input int n, input logic [AW-1:0] base,
                     input logic [DW-1:0] sd, input bit ce, input int corr, input bit nofin,
                     input int hold);
    bit            ew[$];
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    int            ei[$];
    logic [AW-1:0] a, exp_first;
    logic [DW-1:0] d, pred;
    int            exp_err, ndone, t_issue, t_done, cyc, ob, ls;
    exp_err = 0; ndone = 0; t_issue = -1; t_done = -1; cyc = 0; exp_first = '0;
    ob = obs_w.size(); ls = lat_sum;
    // op list straight from the mode definitions
    for (int i = 0; i < n; i++) begin
      a = AW'(64'(base) + 64'(i) * 64'(STR));
      d = sd + DW'(i);
      if (md != 1) begin ew.push_back(1'b1); ea.push_back(a); ed.push_back(d); ei.push_back(i); end
      if (md == 1 || md == 3) begin ew.push_back(1'b0); ea.push_back(a); ed.push_back(d); ei.push_back(i); end
    end
    if (md == 2)
      for (int i = 0; i < n; i++) begin
        ew.push_back(1'b0); ea.push_back(AW'(64'(base) + 64'(i) * 64'(STR)));
        ed.push_back(sd + DW'(i)); ei.push_back(i);
      end
    if (nofin) while (ew.size() > 1) begin void'(ew.pop_back()); void'(ea.pop_back()); void'(ed.pop_back()); void'(ei.pop_back()); end
    for (int k = 0; k < ew.size(); k++) begin
      if (ew[k]) ref_mem[ea[k]] = ed[k];
      else if (!nofin) begin
        pred = ref_mem.exists(ea[k]) ? ref_mem[ea[k]] : junk(ea[k]);
        if (ei[k] == corr) pred = pred ^ 32'd1;
        if (ce && pred != ed[k]) begin
          if (exp_err == 0) exp_first = ea[k];
          exp_err++;
        end
      end
    end

    corrupt = (corr < 0) ? -1 : rd_seen + corr;
    no_fin = nofin;
    mode = 2'(md); num_ops = CW'(n); base_addr = base; seed = sd; check_en = ce; start = 1'b1;
    while (cyc < 3000 && !(t_done >= 0 && cyc >= t_done + 3)) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      if (t_issue < 0 && (core2cache_wr_en || core2cache_rd_en)) t_issue = cyc;
      if (done) begin ndone++; t_done = cyc; end
    end
    start = 1'b0;

    chk({tag, ".done_cnt"}, 64'(ndone), 64'd1);
    chk({tag, ".nops"}, 64'(obs_w.size() - ob), 64'(ew.size()));
    for (int k = 0; k < ew.size() && ob + k < obs_w.size(); k++) begin
      chk({tag, ".kind"}, 64'(obs_w[ob + k]), 64'(ew[k]));
      chk({tag, ".addr"}, 64'(obs_a[ob + k]), 64'(ea[k]));
      if (ew[k]) chk({tag, ".wdata"}, 64'(obs_d[ob + k]), 64'(ed[k]));
    end
    chk({tag, ".err_count"}, 64'(err_count), 64'(exp_err));
    chk({tag, ".first_err"}, 64'(first_err_addr), 64'(exp_first));
    chk({tag, ".timeout"}, 64'(timeout), 64'(nofin));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".cycles"}, 64'(cycle_count), nofin ? 64'(TO) : 64'(lat_sum - ls));
    if (nofin) chk({tag, ".to_lat"}, 64'(t_done - t_issue), 64'(TO));
    if (n == 0) chk({tag, ".done_at"}, 64'(t_done), 64'd1);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, ".addr"}, 64'({core2cache_rd_addr, core2cache_wr_addr}), 64'd0);
    chk({tag, ".wdata"}, 64'(core2cache_wr_data), 64'd0);
    chk({tag, ".ctl"}, 64'({core2cache_rd_en, core2cache_wr_en, busy, done, timeout}), 64'd0);
    chk({tag, ".err"}, 64'({err_count, first_err_addr}), 64'd0);
    chk({tag, ".cyc"}, 64'(cycle_count), 64'd0);
  endtask

  int            r_md, r_n, r_corr;
  logic [AW-1:0] exp_a5;

  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    zero_chk("rst");
    rstn = 1'b1;
    @(negedge clk);

    lat_lo = 3; lat_hi = 3;
    run("m0", 0, 4, '0, 32'h10, 1'b1, -1, 1'b0, 1);
    chk("m0.a3", 64'(obs_a[obs_a.size() - 1]), 64'h1803C24);
    chk("m0.cyc16", 64'(cycle_count), 64'd16);

    lat_lo = 1; lat_hi = 4;
    run("m2", 2, 100, 27'h0123456, 32'hCAFE_0000, 1'b1, -1, 1'b0, 1);

    run("m3", 3, 8, 27'h0ABCDEF, 32'h5555_0000, 1'b1, 5, 1'b0, 1);
    exp_a5 = 27'h0ABCDEF + 27'h0280_643C;
    chk("m3.err1", 64'(err_count), 64'd1);
    chk("m3.first5", 64'(first_err_addr), 64'(exp_a5));

    run("m1to", 1, 5, 27'h0000100, 32'h1, 1'b1, -1, 1'b1, 1);
    run("n0", 0, 0, 27'h0000040, 32'h2, 1'b1, -1, 1'b0, 1);

    lat_lo = 5; lat_hi = 5;
    run("hold", 0, 3, 27'h0000200, 32'h3, 1'b1, -1, 1'b0, 6);

    lat_lo = 1; lat_hi = 4;
    run("wrap", 0, 2, 27'h7FFFFFF, 32'hFFFF_FFFF, 1'b1, -1, 1'b0, 1);
    chk("wrap.a1", 64'(obs_a[obs_a.size() - 1]), 64'h080140B);

    lat_lo = 1; lat_hi = 6;
    for (int r = 0; r < 8; r++) begin
      r_md = int'($urandom_range(3, 0));
      r_n = int'($urandom_range(20, 1));
      r_corr = ($urandom_range(1, 0) == 1) ? int'($urandom_range(r_n - 1, 0)) : -1;
      run("rnd", r_md, r_n, AW'($urandom), $urandom, 1'($urandom_range(1, 0)), r_corr, 1'b0, 1);
    end

    no_fin = 1'b1;
    mode = 2'd1; num_ops = CW'(4); base_addr = 27'h1234567; seed = 32'h9; check_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid.busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    zero_chk("rmid");
    @(negedge clk);
    rstn = 1'b1;
    no_fin = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
